// File: rtl/result_writeback.sv
// result_writeback: buffers result beats and issues lane-parallel memory writes for the output feature map
module result_writeback #(
   parameter int DATA_WIDTH = 16,
   parameter int IMAGE_WIDTH = 8,
   parameter int IMAGE_HEIGHT = 8,
   parameter int NUM_UNITS = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
   localparam int KW = $clog2(IMAGE_WIDTH)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [KW-1:0]                          kernel_dim,
   input  logic [AW-1:0]                          base_addr,
   input  logic                                   res_valid,
   output logic                                   res_ready,
   input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   res_data,
   input  logic                                   mem_busy,
   output logic                                   wr_en,
   output logic [NUM_UNITS-1:0]                   wr_lane_en,
   output logic [NUM_UNITS-1:0][AW-1:0]           wr_addr,
   output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   wr_data,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   err
);
   localparam int CW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + NUM_UNITS + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CTW = PW + 1;
   localparam int EW = NUM_UNITS * (DATA_WIDTH + AW + 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt, cnt_n, col, col_n, ow, total, ow_n, oh_n, total_n, k_ext, c;
   logic [AW-1:0] row_addr, ra, ra_n;
   logic wrap, k_bad, push, pop;
   logic [NUM_UNITS-1:0][AW-1:0] lane_addr;
   logic [NUM_UNITS-1:0] lane_en;
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CTW-1:0] count;
   logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] h_data;
   logic [NUM_UNITS-1:0][AW-1:0] h_addr;
   logic [NUM_UNITS-1:0] h_en;

   assign k_ext = CW'(kernel_dim);
   assign ow_n = CW'(IMAGE_WIDTH) - k_ext + CW'(1);
   assign oh_n = CW'(IMAGE_HEIGHT) - k_ext + CW'(1);
   assign total_n = ow_n * oh_n;
   assign k_bad = (kernel_dim == '0) || (k_ext > CW'(IMAGE_HEIGHT));
   assign res_ready = (state == RUN) && (count != CTW'(FIFO_DEPTH));
   assign push = res_valid && res_ready;
   assign pop = !mem_busy && (count != '0);
   assign cnt_n = cnt + CW'(NUM_UNITS);
   assign {h_data, h_addr, h_en} = fifo_mem[rptr];

   // walk the lanes of the beat across the output row, carrying into the next memory row at ow
   always_comb begin
      c = col;
      ra = row_addr;
      wrap = 1'b0;
      lane_addr = '0;
      lane_en = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         lane_addr[i] = ra + AW'(c);
         lane_en[i] = (cnt + CW'(i)) < total;
         wrap = (c + CW'(1)) == ow;
         ra = wrap ? ra + AW'(IMAGE_WIDTH) : ra;
         c = wrap ? '0 : c + CW'(1);
      end
      col_n = c;
      ra_n = ra;
   end

   // control FSM: geometry latch, beat acceptance, drain and completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         col <= '0;
         row_addr <= '0;
         ow <= '0;
         total <= '0;
         err <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               ow <= ow_n;
               total <= total_n;
               err <= k_bad;
               cnt <= '0;
               col <= '0;
               row_addr <= base_addr;
               busy <= 1'b1;
               done <= k_bad;
               state <= k_bad ? DONE : RUN;
            end
            RUN: if (push) begin
               cnt <= cnt_n;
               col <= col_n;
               row_addr <= ra_n;
               state <= (cnt_n >= total) ? DRAIN : RUN;
            end
            DRAIN: if (count == '0 && !wr_en) begin
               done <= 1'b1;
               state <= DONE;
            end
            default: begin
               done <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; reset discards any buffered beats
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         wptr <= push ? wptr + PW'(1) : wptr;
         rptr <= pop ? rptr + PW'(1) : rptr;
         count <= count + CTW'(push) - CTW'(pop);
      end
   end

   // FIFO storage, written with the resolved lane addresses and enables
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr] <= {res_data, lane_addr, lane_en};
   end

   // registered write port; address and data hold between writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en <= 1'b0;
         wr_lane_en <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= pop;
         wr_lane_en <= pop ? h_en : '0;
         wr_addr <= pop ? h_addr : wr_addr;
         wr_data <= pop ? h_data : wr_data;
      end
   end
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: scoreboard bench for result_writeback with directed geometry vectors
module tb_result_writeback;
   typedef struct packed {
      logic [1:0] en;
      logic [1:0][5:0] addr;
      logic [1:0][15:0] data;
   } wr_t;
   typedef struct {
      wr_t w;
      int cyc;
   } log_t;

   logic clk = 0, reset = 0, start = 0, res_valid = 0, mem_busy = 0;
   logic [2:0] kernel_dim = 0;
   logic [5:0] base_addr = 0;
   logic [1:0][15:0] res_data = '0;
   logic res_ready, wr_en, busy, done, err;
   logic [1:0] wr_lane_en;
   logic [1:0][5:0] wr_addr;
   logic [1:0][15:0] wr_data;

   int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, acc_cnt = 0;
   wr_t exp_q[$];
   log_t wr_log[$];

   result_writeback dut (
      .clk(clk), .reset(reset), .start(start), .kernel_dim(kernel_dim), .base_addr(base_addr),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .mem_busy(mem_busy),
      .wr_en(wr_en), .wr_lane_en(wr_lane_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic wr_t model(input int k, input int base, input int n);
      wr_t m;
      int ow, tot, idx;
      ow = 9 - k;
      tot = ow * (9 - k);
      m = '0;
      for (int i = 0; i < 2; i++) begin
         idx = 2 * n + i;
         m.en[i] = idx < tot;
         m.addr[i] = 6'((base + (idx / ow) * 8 + idx % ow) % 64);
         m.data[i] = 16'(idx);
      end
      return m;
   endfunction

   function automatic bit match(input wr_t a, input wr_t e);
      if (a.en != e.en) return 0;
      for (int i = 0; i < 2; i++)
         if (e.en[i] && (a.addr[i] != e.addr[i] || a.data[i] != e.data[i])) return 0;
      return 1;
   endfunction

   always @(negedge clk) begin
      wr_t a, e;
      if (reset) begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (wr_en) begin
            a.en = wr_lane_en;
            a.addr = wr_addr;
            a.data = wr_data;
            wr_log.push_back('{a, cyc});
            last_wr_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write got en=%b addr=%h data=%h, none required", a.en, a.addr, a.data);
            end else begin
               e = exp_q.pop_front();
               if (!match(a, e)) begin
                  errors++;
                  $display("FAIL write got en=%b addr=%h data=%h required en=%b addr=%h data=%h",
                           a.en, a.addr, a.data, e.en, e.addr, e.data);
               end
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, act, req);
      end
   endtask

   task automatic clear_logs();
      wr_log.delete();
      done_cnt = 0;
      acc_cnt = 0;
   endtask

   task automatic start_run(input int k, input int base);
      @(posedge clk); #1;
      kernel_dim = 3'(k);
      base_addr = 6'(base);
      start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic send_beats(input int k, input int base, input int nb);
      bit acc;
      int t;
      for (int n = 0; n < nb; n++) begin
         res_data[0] = 16'(2 * n);
         res_data[1] = 16'(2 * n + 1);
         res_valid = 1;
         acc = 0;
         t = 0;
         while (!acc) begin
            @(negedge clk);
            acc = res_ready;
            @(posedge clk); #1;
            t++;
            if (!acc && t > 200) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout beat %0d not accepted in %0d cycles", n, t);
               res_valid = 0;
               return;
            end
         end
         exp_q.push_back(model(k, base, n));
         acc_cnt++;
      end
      res_valid = 0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", int'(done), 1);
   endtask

   initial begin
      int hits;
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_res_ready", int'(res_ready), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), 0);
      check("rst_busy_done_err", int'({busy, done, err}), 0);
      reset = 1;

      // geometry and first beats, k=3 base=0
      clear_logs();
      start_run(3, 0);
      check("busy_run", int'(busy), 1);
      send_beats(3, 0, 18);
      wait_done(100);
      repeat (4) @(posedge clk);
      #1;
      check("g_writes", wr_log.size(), 18);
      check("g_b0_addr", int'(wr_log[0].w.addr), {6'd1, 6'd0});
      check("g_b0_data", int'(wr_log[0].w.data), {16'd1, 16'd0});
      check("g_b3_addr", int'(wr_log[3].w.addr), {6'd9, 6'd8});
      check("g_b17_addr", int'(wr_log[17].w.addr), {6'd45, 6'd44});
      check("g_done_cnt", done_cnt, 1);
      check("g_done_lag", done_cyc - last_wr_cyc, 2);
      check("g_err", int'(err), 0);
      check("g_busy_idle", int'(busy), 0);
      check("g_exp_left", exp_q.size(), 0);

      // partial last beat, k=2
      clear_logs();
      start_run(2, 0);
      send_beats(2, 0, 25);
      wait_done(100);
      repeat (4) @(posedge clk);
      #1;
      check("p_writes", wr_log.size(), 25);
      check("p_last_en", int'(wr_log[24].w.en), 1);
      check("p_last_addr0", int'(wr_log[24].w.addr[0]), 54);
      hits = 0;
      foreach (wr_log[j])
         for (int i = 0; i < 2; i++)
            if (wr_log[j].w.en[i] && wr_log[j].w.addr[i] == 6'd55) hits++;
      check("p_no_55", hits, 0);
      check("p_exp_left", exp_q.size(), 0);

      // back-pressure, k=3
      clear_logs();
      mem_busy = 1;
      start_run(3, 0);
      fork
         send_beats(3, 0, 18);
         begin
            repeat (6) @(posedge clk);
            #1;
            check("bp_accepts", acc_cnt, 4);
            check("bp_ready_low", int'(res_ready), 0);
            check("bp_no_write", wr_log.size(), 0);
            mem_busy = 0;
         end
      join
      wait_done(100);
      repeat (4) @(posedge clk);
      #1;
      check("bp_writes", wr_log.size(), 18);
      check("bp_consec", wr_log[3].cyc - wr_log[0].cyc, 3);
      check("bp_exp_left", exp_q.size(), 0);

      // base offset with wrap, plus a start during RUN that must be ignored
      clear_logs();
      start_run(3, 60);
      fork
         send_beats(3, 60, 18);
         begin
            repeat (2) @(posedge clk);
            #1;
            start = 1;
            base_addr = 0;
            kernel_dim = 2;
            @(posedge clk); #1;
            start = 0;
         end
      join
      wait_done(100);
      repeat (4) @(posedge clk);
      #1;
      check("w_b0_addr", int'(wr_log[0].w.addr), {6'd61, 6'd60});
      check("w_b3_addr", int'(wr_log[3].w.addr), {6'd5, 6'd4});
      check("w_writes", wr_log.size(), 18);
      check("w_done_cnt", done_cnt, 1);

      // invalid kernel
      clear_logs();
      start_run(0, 0);
      wait_done(2);
      check("k0_err", int'(err), 1);
      repeat (5) @(posedge clk);
      #1;
      check("k0_no_write", wr_log.size(), 0);
      check("k0_done_cnt", done_cnt, 1);
      check("k0_err_sticky", int'(err), 1);

      // reset mid-run
      clear_logs();
      mem_busy = 1;
      start_run(3, 0);
      check("r_err_cleared", int'(err), 0);
      send_beats(3, 0, 4);
      res_data[0] = 16'd8;
      res_data[1] = 16'd9;
      res_valid = 1;
      @(posedge clk); #1;
      reset = 0;
      #1;
      check("r_res_ready", int'(res_ready), 0);
      check("r_wr_en", int'(wr_en), 0);
      check("r_lane_en", int'(wr_lane_en), 0);
      check("r_wr_addr", int'(wr_addr), 0);
      check("r_wr_data", int'(wr_data), 0);
      check("r_busy_done_err", int'({busy, done, err}), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      res_valid = 0;
      mem_busy = 0;
      repeat (10) @(posedge clk);
      #1;
      check("r_no_write", wr_log.size(), 0);
      check("r_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
